// File: rtl/fetch_pkg.sv
// Shared types and constants for the F-stage fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

  // Instruction slot presented at the F/D boundary.
  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
  } f_slot_t;

  // Redirect targets are word addresses; the low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_seq.sv
// F-stage sequencer: owns the fetch PC, runs a single-outstanding IM handshake
// and holds the delivered instruction until the D stage consumes it.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned IM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        branch,
  input  logic [31:0] DnPC,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        F_valid,
  output logic [31:0] F_ins,
  output logic [31:0] F_PC,
  output logic        F_err
);

  localparam int unsigned CW = $clog2(IM_TIMEOUT + 1);

  fetch_state_t  state;
  logic [31:0]   next_pc;
  logic [31:0]   cur_pc;
  logic [CW-1:0] wait_cnt;
  f_slot_t       slot;
  logic          req_q;
  logic          valid_q;
  logic          err_q;

  logic [31:0]   redirect_c;
  logic          timeout_c;

  assign redirect_c = word_align(DnPC);
  assign timeout_c  = (wait_cnt == CW'(IM_TIMEOUT));

  // Sequencer state, PC bookkeeping and registered F outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      next_pc  <= RESET_PC;
      cur_pc   <= RESET_PC;
      wait_cnt <= '0;
      slot     <= '{ins: 32'd0, pc: RESET_PC};
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (im_ready) begin
            // The accepted address is the delay slot; a coincident branch
            // only steers what comes after it.
            cur_pc   <= next_pc;
            next_pc  <= branch ? redirect_c : next_pc + PC_STEP;
            wait_cnt <= '0;
            req_q    <= 1'b0;
            state    <= WAIT;
          end else if (branch) begin
            next_pc <= redirect_c;
          end
        end
        WAIT: begin
          if (im_rvalid) begin
            slot    <= '{ins: im_rdata, pc: cur_pc};
            valid_q <= 1'b1;
            state   <= HOLD;
          end else if (timeout_c) begin
            err_q <= 1'b1;
            req_q <= 1'b1;
            state <= REQ;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
          if (branch) begin
            next_pc <= redirect_c;
          end else if (!im_rvalid && timeout_c) begin
            next_pc <= cur_pc;
          end
        end
        HOLD: begin
          if (!pause) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state   <= REQ;
          end
          if (branch) begin
            next_pc <= redirect_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign im_req  = req_q;
  assign im_addr = next_pc;
  assign F_valid = valid_q;
  assign F_ins   = slot.ins;
  assign F_PC    = slot.pc;
  assign F_err   = err_q;

endmodule
